// File: rtl/write_buffer.sv
// write_buffer: DEPTH-entry store FIFO between the CPU and data memory.
// Accepted stores are drained in order over a valid/ready handshake, and
// loads can pick up buffered data through a combinational forwarding lookup.
// Optional build macro: WB_COALESCE_EN -- a store that hits a pending
// non-head entry overwrites its data in place instead of allocating.
module write_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0]    wd,
  output logic                     stall,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     fwd_hit,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic                     mem_ready,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] addr_reg [DEPTH];
  logic [DATA_WIDTH-1:0]    data_reg [DEPTH];
  logic [DEPTH-1:0]         valid_reg;
  logic [PTR_W-1:0]         head_reg, head_next;
  logic [PTR_W-1:0]         tail_reg, tail_next;
  logic [PTR_W:0]           count_reg, count_next;

  logic [DEPTH-1:0] rd_match;
  logic [DEPTH-1:0] coal_match;
  logic [PTR_W-1:0] fwd_idx;
  logic             full, pop, coal_hit, push_alloc, coal_write;

  assign mem_we = (count_reg != '0);
  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FULL_COUNT);
  assign pop    = mem_we && mem_ready;

  // Head entry is presented straight from the registers; zero when idle.
  assign mem_a  = mem_we ? addr_reg[head_reg] : '0;
  assign mem_wd = mem_we ? data_reg[head_reg] : '0;

  // Per-entry address comparators for load forwarding and store coalescing.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_match
    assign rd_match[gi] = valid_reg[gi] && (addr_reg[gi] == rd_addr);
`ifdef WB_COALESCE_EN
    // The presented head is never modified, so it is excluded from merging.
    assign coal_match[gi] = valid_reg[gi] && (addr_reg[gi] == alu_result) &&
                            !(mem_we && (head_reg == PTR_W'(gi)));
`else
    assign coal_match[gi] = 1'b0;
`endif
  end

  assign coal_hit   = |coal_match;
  // A merging store never needs a free slot; a full buffer still accepts a
  // store in the cycle its head drains.
  assign stall      = we && !coal_hit && full && !pop;
  assign push_alloc = we && !stall && !coal_hit;
  assign coal_write = we && coal_hit;

  // Walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (rd_match[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_reg[fwd_idx];
      end
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (pop)        head_next = head_reg + PTR_W'(1);
    if (push_alloc) tail_next = tail_reg + PTR_W'(1);
    case ({push_alloc, pop})
      2'b10:   count_next = count_reg + (PTR_W+1)'(1);
      2'b01:   count_next = count_reg - (PTR_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage: allocation at tail wins over the pop clearing the same
  // slot, which happens when a full buffer pushes and pops together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        addr_reg[i]  <= '0;
        data_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_alloc && (tail_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b1;
          addr_reg[i]  <= alu_result;
          data_reg[i]  <= wd;
        end else if (coal_write && coal_match[i]) begin
          data_reg[i]  <= wd;
        end else if (pop && (head_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

endmodule
